// File: rtl/hive_reg_timer_pkg.sv
// hive_reg_timer_pkg: shared types and constants for the rbus timer peripheral.
//   - bus widths (ALU_W, RBUS_ADDR_W), prescale width, rbus base address
//   - register offsets TMR_TIME..TMR_PRE and CTL bit positions
//   - TMR_STATE_T: down-counter state machine encoding
package hive_reg_timer_pkg;

  localparam int ALU_W       = 32;
  localparam int RBUS_ADDR_W = 8;
  localparam int PRE_W       = 16;

  localparam logic [RBUS_ADDR_W-1:0] RBUS_BASE = 8'h10;

  // Register offsets from RBUS_BASE
  localparam logic [2:0] TMR_TIME = 3'd0;
  localparam logic [2:0] TMR_CNT  = 3'd1;
  localparam logic [2:0] TMR_RLD  = 3'd2;
  localparam logic [2:0] TMR_CTL  = 3'd3;
  localparam logic [2:0] TMR_PRE  = 3'd4;

  // CTL bit positions
  localparam int TMR_EN_B  = 0;
  localparam int TMR_PER_B = 1;
  localparam int TMR_IE_B  = 2;
  localparam int TMR_EXP_B = 8;
  localparam int TMR_CLR_B = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } TMR_STATE_T;

endpackage

// File: rtl/hive_reg_timer_if.sv
// hive_reg_timer_if: rbus register-port bundle between the data ring and the timer.
//   rbus_addr_i     register address
//   rbus_wr_i       write enable, active high
//   rbus_rd_i       read enable, active high
//   rbus_wr_data_i  write data
//   rbus_rd_data_o  read data, zero when not addressed (OR-bus)
// master: ring side; slave: peripheral side.
interface hive_reg_timer_if;
  import hive_reg_timer_pkg::*;

  logic [RBUS_ADDR_W-1:0] rbus_addr_i;
  logic                   rbus_wr_i;
  logic                   rbus_rd_i;
  logic [ALU_W-1:0]       rbus_wr_data_i;
  logic [ALU_W-1:0]       rbus_rd_data_o;

  modport master (
    output rbus_addr_i, rbus_wr_i, rbus_rd_i, rbus_wr_data_i,
    input  rbus_rd_data_o
  );

  modport slave (
    input  rbus_addr_i, rbus_wr_i, rbus_rd_i, rbus_wr_data_i,
    output rbus_rd_data_o
  );

endinterface

// File: rtl/hive_timer_tick.sv
// hive_timer_tick: prescaler producing the down-counter tick.
//   clk_i      clock
//   rst_i      async reset, active high
//   restart_i  restart the prescale phase at 0 (CTL write with EN=1)
//   pre_i      prescale value; a tick every pre_i+1 clks
//   tick_o     tick pulse, one clk wide
// Macro HIVE_TIMER_PRESCALE_EN: when undefined no counter is built and tick_o is
// tied high (a tick every clk).
module hive_timer_tick
  import hive_reg_timer_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             restart_i,
  input  logic [PRE_W-1:0] pre_i,
  output logic             tick_o
);

`ifdef HIVE_TIMER_PRESCALE_EN
  logic [PRE_W-1:0] div_cnt_reg;

  // >= rather than == so that lowering PRE below the running count cannot
  // stall the prescaler for a full 2^PRE_W wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      div_cnt_reg <= '0;
    else if (restart_i || (div_cnt_reg >= pre_i))
      div_cnt_reg <= '0;
    else
      div_cnt_reg <= div_cnt_reg + 1'b1;
  end

  assign tick_o = (div_cnt_reg >= pre_i);
`else
  logic unused_tick;
  assign unused_tick = &{1'b0, clk_i, rst_i, restart_i, pre_i};
  assign tick_o = 1'b1;
`endif

endmodule

// File: rtl/hive_reg_timer.sv
// hive_reg_timer: rbus timer peripheral (free-running TIME, loadable CNT
// down-counter with one-shot/periodic modes, level interrupt).
//   clk_i  clock
//   rst_i  async reset, active high
//   bus    rbus slave port (addr, wr, rd, wr_data in; rd_data out, 1-clk latency)
//   irq_o  interrupt, EXP & IE
// Macro HIVE_TIMER_PRESCALE_EN: adds the 16-bit PRE register at +4 and the
// prescaler; otherwise +4 is unmapped and a tick occurs every clk.
module hive_reg_timer
  import hive_reg_timer_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  hive_reg_timer_if.slave  bus,
  output logic             irq_o
);

`ifdef HIVE_TIMER_PRESCALE_EN
  localparam logic [2:0] LAST_SEL = TMR_PRE;
`else
  localparam logic [2:0] LAST_SEL = TMR_CTL;
`endif

  logic [RBUS_ADDR_W-1:0] offs;
  logic [2:0]             sel;
  logic                   hit, wr_hit, rd_hit, wr_ctl, wr_en;
  logic                   tick, exp_set;
  logic [ALU_W-1:0]       time_reg, cnt_reg, cnt_next, rld_reg, rd_data_reg, rd_mux;
  logic                   per_reg, ie_reg, exp_reg;
  logic [PRE_W-1:0]       pre_val;
  TMR_STATE_T             state_reg, state_next;

  // Addresses below RBUS_BASE wrap to large offsets and miss.
  assign offs   = bus.rbus_addr_i - RBUS_BASE;
  assign sel    = offs[2:0];
  assign hit    = (offs[RBUS_ADDR_W-1:3] == '0) && (sel <= LAST_SEL);
  assign wr_hit = bus.rbus_wr_i && hit;
  assign rd_hit = bus.rbus_rd_i && hit;
  assign wr_ctl = wr_hit && (sel == TMR_CTL);
  assign wr_en  = bus.rbus_wr_data_i[TMR_EN_B];

`ifdef HIVE_TIMER_PRESCALE_EN
  logic [PRE_W-1:0] pre_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      pre_reg <= '0;
    else if (wr_hit && (sel == TMR_PRE))
      pre_reg <= bus.rbus_wr_data_i[PRE_W-1:0];
  end

  assign pre_val = pre_reg;
`else
  assign pre_val = '0;
`endif

  hive_timer_tick u_tick (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (wr_ctl && wr_en),
    .pre_i     (pre_val),
    .tick_o    (tick)
  );

  // Next state / next count. A stop write (EN=0) overrides the tick on the
  // same edge: the count freezes and that tick neither decrements nor expires.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    exp_set    = 1'b0;
    if ((state_reg == RUN) && tick) begin
      if (cnt_reg == '0) begin
        exp_set = 1'b1;
        if (per_reg)
          cnt_next = rld_reg;
        else
          state_next = DONE;
      end else begin
        cnt_next = cnt_reg - 1'b1;
      end
    end
    if (wr_ctl) begin
      if (!wr_en) begin
        state_next = IDLE;
        cnt_next   = cnt_reg;
        exp_set    = 1'b0;
      end else if (state_reg != RUN) begin
        state_next = RUN;
        cnt_next   = rld_reg;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      time_reg    <= '0;
      cnt_reg     <= '0;
      rld_reg     <= '0;
      per_reg     <= 1'b0;
      ie_reg      <= 1'b0;
      exp_reg     <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      if (wr_hit && (sel == TMR_TIME))
        time_reg <= bus.rbus_wr_data_i;
      else
        time_reg <= time_reg + 1'b1;
      if (wr_hit && (sel == TMR_RLD))
        rld_reg <= bus.rbus_wr_data_i;
      if (wr_ctl) begin
        per_reg <= bus.rbus_wr_data_i[TMR_PER_B];
        ie_reg  <= bus.rbus_wr_data_i[TMR_IE_B];
      end
      // Set has priority over write-1-clear.
      if (exp_set)
        exp_reg <= 1'b1;
      else if (wr_ctl && bus.rbus_wr_data_i[TMR_CLR_B])
        exp_reg <= 1'b0;
      rd_data_reg <= rd_hit ? rd_mux : '0;
    end
  end

  // Read mux sees pre-write register values. EN is 1 exactly while in RUN.
  always_comb begin
    rd_mux = '0;
    case (sel)
      TMR_TIME: rd_mux = time_reg;
      TMR_CNT:  rd_mux = cnt_reg;
      TMR_RLD:  rd_mux = rld_reg;
      TMR_CTL: begin
        rd_mux[TMR_EN_B]  = (state_reg == RUN);
        rd_mux[TMR_PER_B] = per_reg;
        rd_mux[TMR_IE_B]  = ie_reg;
        rd_mux[TMR_EXP_B] = exp_reg;
      end
      TMR_PRE:  rd_mux = ALU_W'(pre_val);
      default:  rd_mux = '0;
    endcase
  end

  assign bus.rbus_rd_data_o = rd_data_reg;
  assign irq_o              = exp_reg & ie_reg;

endmodule

// File: doc/hive_reg_timer.md
# hive_reg_timer

Register-bus timer peripheral that sits directly downstream of the processor data ring's rbus port. It sits alongside the error and GPIO registers, and its read data is ORed into the ring's rbus read-data return. It provides:
- a free-running time counter;
- a loadable down-counter with one-shot and periodic modes;
- a level interrupt output routed to the core's irq input.

## Interface
- RBUS_BASE, 'h10, rbus address of register 0; registers occupy RBUS_BASE+0 .. RBUS_BASE+4
- clk_i  in  1  clock
- rst_i  in  1  async. reset, active high
- rbus_addr_i  in  RBUS_ADDR_W  register address
- rbus_wr_i  in  1  write enable, active high
- rbus_rd_i  in  1  read enable, active high
- rbus_wr_data_i  in  ALU_W  write data
- rbus_rd_data_o  out  ALU_W  read data; zero when not addressed (OR-bus)
- irq_o  out  1  timer interrupt, level, active high

## Operation
- Register map, offsets from RBUS_BASE:
  - +0 TIME: free-running up-counter, +1 every clk, wraps at 2^ALU_W. A write loads the written value.
  - +1 CNT: current down-counter value. Read-only; writes are ignored.
  - +2 RLD: reload value, read/write.
  - +3 CTL: bit0 EN, bit1 PER (periodic), bit2 IE (irq enable), bit8 EXP (expired, read-only).
    - Writing 1 to CTL bit9 clears EXP; writing 0 to bit9 has no effect.
    - All other bits read 0.
  - +4 PRE: prescale register; exists only when the configuration macro is defined (see Configuration).
- The state machine (TMR_STATE_T) has three states: IDLE, RUN, DONE.
  - IDLE: CNT is held. A CTL write with EN=1 loads CNT<=RLD and moves to RUN.
  - RUN: CNT decrements by 1 on each tick.
    - A tick with CNT==0 sets EXP.
    - If PER=1, the same tick reloads CNT<=RLD and the block stays in RUN.
    - If PER=0, CNT stays 0, EN is cleared, and the block moves to DONE.
  - DONE: CTL write with EN=1 behaves as in IDLE (reload and go to RUN). A write with EN=0 moves to IDLE.
  - In any state, a CTL write with EN=0 moves to IDLE and CNT holds its current value.
  - A CTL write with EN=1 while already in RUN updates PER/IE only. There is no reload.
- irq_o = EXP & IE. It is a level signal and stays high until EXP is cleared or IE is written 0.
- Boundary conditions:
  - RLD=0 in periodic mode: EXP is set on every tick.
  - RLD written during RUN: takes effect at the next reload only.
  - EXP set and write-1-clear in the same cycle: set wins, EXP stays 1.
  - TIME write and increment in the same cycle: the write wins, and TIME is the written value the next cycle.
  - A read and write to the same register in the same cycle returns the pre-write value.
  - Reads and writes to unmapped offsets are ignored and return 0.

## Timing
- Register writes take effect on the clk edge on which rbus_wr_i is sampled high.
- Read latency is 1 clk: data is registered, valid the cycle after rbus_rd_i with a matching address, and 0 otherwise.
- EXP and irq_o assert 1 clk after the expiring tick.
- From the CTL enable write to the first expiry: (RLD+1) ticks.
- Reset values:
  - TIME, CNT, RLD, PRE: 0.
  - CTL: 0.
  - State: IDLE.
  - rbus_rd_data_o: 0.
  - irq_o: 0.
- Asserting rst_i mid-count returns every register to reset values immediately (async). Nothing pending survives reset.

## Configuration
- HIVE_TIMER_PRESCALE_EN defined:
  - PRE is a 16-bit read/write register at +4; read data is zero-extended.
  - A tick occurs once every PRE+1 clks, from a prescale counter that restarts at 0 on every CTL write with EN=1.
  - TIME is unaffected and always counts clks.
- HIVE_TIMER_PRESCALE_EN undefined:
  - A tick occurs every clk.
  - +4 reads 0 and writes to it are ignored.
  - No prescale logic is generated.

## Structure
- Add to hive_types:
  - TMR_STATE_T enum (IDLE, RUN, DONE).
- Add to hive_params:
  - register offset constants TMR_TIME, TMR_CNT, TMR_RLD, TMR_CTL, TMR_PRE;
  - CTL bit positions TMR_EN_B, TMR_PER_B, TMR_IE_B, TMR_EXP_B, TMR_CLR_B.
- One sub-module: hive_timer_tick, the prescale counter that emits a single-clk tick pulse. When the macro is undefined it is bypassed and the tick is tied high.
- In the data ring, the timer's rbus_rd_data_o is ORed into rbus_rd_data_2, and irq_o drives the core's irq input.

## Test plan
- Reset, then read all offsets +0..+4 -> every read returns 0 one clk later except TIME, which returns its count; irq_o=0.
- RLD=3, CTL=0x5 (EN, IE, one-shot), no prescale -> EXP and irq_o rise 4 clks after the CTL write; CTL reads 0x104; CNT reads 0; state DONE.
- RLD=0, CTL=0x7 (periodic) -> EXP set on every tick. Write CTL=0x207 on the same cycle as an expiry -> EXP remains 1.
- Periodic run with RLD=5, then write RLD=2 mid-count -> the current period completes at 6 ticks, and following periods are 3 ticks.
- Write CTL=0 mid-run at CNT=2 -> CNT holds at 2, state IDLE. Assert rst_i mid-run -> CNT=0, irq_o=0 immediately.
- With HIVE_TIMER_PRESCALE_EN: PRE=3, RLD=1, one-shot -> expiry 8 clks after enable. Without the macro: write 3 to +4 -> +4 reads 0.
